// File: rtl/rr_dispatch_pkg.sv
// Shared constants and helpers for the round-robin dispatcher.
// Latency: n/a (constants and a pure combinational helper only).
// Backpressure: n/a.
// Contents: default channel count, default payload width, rr_ptr reset
// value (sliced to NUM_OUT bits by users), and an index-wrap helper.
package rr_dispatch_pkg;

  localparam int RR_NUM_OUT_DEF = 4;
  localparam int RR_DATA_W_DEF  = 32;

  // One-hot channel 0; users take the low NUM_OUT bits.
  localparam logic [63:0] RR_PTR_RST = 64'd1;

  // Wrap a channel index into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return idx % n;
  endfunction

endpackage

// File: rtl/rr_dispatcher_pick.sv
// Rotating-priority picker: first requesting bit at or after a one-hot start.
// Latency: combinational.
// Backpressure: none; an all-zero request vector yields an all-zero pick.
// Ports: i_req   request vector (bit i = channel i may be chosen)
//        i_start one-hot start position of the search
//        o_pick  one-hot winner, or zero when nothing requests
module rotate_priority_pick
  import rr_dispatch_pkg::*;
#(
  parameter int N = RR_NUM_OUT_DEF
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_start,
  output logic [N-1:0] o_pick
);

  always_comb begin
    int   s;
    int   j;
    logic found;
    s      = 0;
    j      = 0;
    found  = 1'b0;
    o_pick = '0;
    for (int i = 0; i < N; i++) begin
      if (i_start[i]) s = i;
    end
    // Walk upward from the start index, wrapping, and keep the first hit.
    for (int k = 0; k < N; k++) begin
      j = rr_wrap(s + k, N);
      if (!found && i_req[j]) begin
        o_pick[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: one input stream fanned out to NUM_OUT one-deep channels.
// Latency: 1 cycle from accept to out_valid on the target channel.
// Backpressure: in_ready falls when the target channel is full and not draining.
// Ports: clk/rst (sync active-high), dispatch_enable (1 = rotate, 0 = route by
//        lowest bit of single_mask), in_valid/in_data/in_ready input handshake,
//        out_valid/out_data/out_ready per-channel outputs, rr_ptr one-hot next channel.
// Build option RR_DISPATCH_SKIP_EN: rotation skips busy channels and takes the
// first free one from rr_ptr upward, instead of stalling on a busy rr_ptr.
module rr_dispatcher
  import rr_dispatch_pkg::*;
#(
  parameter int NUM_OUT = RR_NUM_OUT_DEF,
  parameter int DATA_W  = RR_DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dispatch_enable,
  input  logic [NUM_OUT-1:0]        single_mask,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [NUM_OUT-1:0]        out_valid,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT-1:0]        rr_ptr
);

  logic [NUM_OUT-1:0] r_hold_vld;
  logic [DATA_W-1:0]  r_hold_dat [NUM_OUT];
  logic [NUM_OUT-1:0] r_ptr;

  logic [NUM_OUT-1:0] w_free;
  logic [NUM_OUT-1:0] w_req;
  logic [NUM_OUT-1:0] w_pick;
  logic [NUM_OUT-1:0] w_fixed;
  logic [NUM_OUT-1:0] w_target;
  logic [NUM_OUT-1:0] w_next_ptr;
  logic               w_xfer;

  // A channel can take a word if empty or if its current word leaves this cycle.
  assign w_free = ~r_hold_vld | out_ready;

`ifdef RR_DISPATCH_SKIP_EN
  assign w_req = w_free;
`else
  // Only the pointed-to channel may win, so a busy rr_ptr stalls the input.
  assign w_req = w_free & r_ptr;
`endif

  rotate_priority_pick #(
    .N (NUM_OUT)
  ) u_pick (
    .i_req   (w_req),
    .i_start (r_ptr),
    .o_pick  (w_pick)
  );

  // Isolate the lowest set bit of the fixed-route mask.
  assign w_fixed    = single_mask & (~single_mask + NUM_OUT'(1));
  assign w_target   = dispatch_enable ? w_pick : w_fixed;
  assign in_ready   = ~rst & (|(w_target & w_free));
  assign w_xfer     = in_valid & in_ready;
  assign w_next_ptr = {w_target[NUM_OUT-2:0], w_target[NUM_OUT-1]};

  assign out_valid = rst ? '0 : r_hold_vld;
  assign rr_ptr    = r_ptr;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_data[g*DATA_W +: DATA_W] = r_hold_dat[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_vld <= '0;
      r_ptr      <= RR_PTR_RST[NUM_OUT-1:0];
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        // Refill wins over drain so back-to-back words show no bubble.
        if (w_xfer && w_target[i]) begin
          r_hold_vld[i] <= 1'b1;
        end else if (out_ready[i]) begin
          r_hold_vld[i] <= 1'b0;
        end
      end
      if (w_xfer && dispatch_enable) begin
        r_ptr <= w_next_ptr;
      end
    end
  end

  // Payload needs no reset: it is only visible while its valid bit is set,
  // and in_ready is low during reset so nothing loads then.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT; i++) begin
      if (w_xfer && w_target[i]) begin
        r_hold_dat[i] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_rr_dispatcher.sv
// Self-checking bench for rr_dispatcher (NUM_OUT=4, DATA_W=32).
// Latency: n/a. Backpressure: driven from directed steps and random out_ready.
// A channel-index reference model predicts every output each cycle.
module tb_rr_dispatcher;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           dispatch_enable;
  logic [N-1:0]   single_mask;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_ready;
  logic [N-1:0]   rr_ptr;

  rr_dispatcher #(.NUM_OUT(N), .DATA_W(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .dispatch_enable (dispatch_enable),
    .single_mask     (single_mask),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .rr_ptr          (rr_ptr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: which channels hold a word, what word, next channel index.
  bit         m_vld [N];
  logic [W-1:0] m_dat [N];
  int         m_ptr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_free(input int c);
    return !m_vld[c] || out_ready[c];
  endfunction

  // Channel index the current inputs would be written to, or -1 if stalled.
  function automatic int model_target();
    int t;
    t = -1;
    if (rst) return -1;
    if (dispatch_enable) begin
`ifdef RR_DISPATCH_SKIP_EN
      for (int k = 0; k < N; k++) begin
        if (t < 0 && m_free((m_ptr + k) % N)) t = (m_ptr + k) % N;
      end
`else
      if (m_free(m_ptr)) t = m_ptr;
`endif
    end else begin
      for (int i = 0; i < N; i++) begin
        if (t < 0 && single_mask[i]) t = i;
      end
      if (t >= 0 && !m_free(t)) t = -1;
    end
    return t;
  endfunction

  // Check all outputs against the model, advance the model, and step one clock.
  task automatic cyc();
    logic [N-1:0]   ev;
    logic [N-1:0]   ep;
    logic [127:0]   ed;
    logic [127:0]   od;
    int             t;
    #2;
    t  = model_target();
    ev = '0;
    ep = '0;
    ed = '0;
    od = '0;
    ep[m_ptr] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!rst && m_vld[i]) begin
        ev[i]          = 1'b1;
        ed[i*W +: W]   = m_dat[i];
        od[i*W +: W]   = out_data[i*W +: W];
      end
    end
    chk("in_ready", 128'(in_ready), 128'(t >= 0));
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("out_data", od, ed);
    chk("rr_ptr", 128'(rr_ptr), 128'(ep));
    if (rst) begin
      for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
      m_ptr = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid && t == i) begin
          m_vld[i] = 1'b1;
          m_dat[i] = in_data;
        end else if (out_ready[i]) begin
          m_vld[i] = 1'b0;
        end
      end
      if (in_valid && t >= 0 && dispatch_enable) m_ptr = (t + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    dispatch_enable = 1'b1;
    single_mask     = '0;
    in_valid        = 1'b0;
    in_data         = '0;
    out_ready       = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0;
      m_dat[i] = '0;
    end
    m_ptr = 0;
    cyc();                       // still in reset: in_ready=0, out_valid=0, rr_ptr=0001

    // Back-to-back rotation with all consumers ready.
    rst       = 1'b0;
    out_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(k);
      #1 chk("r021_rdy", 128'(in_ready), 128'(1));
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("r021_ch0", 128'(out_data[31:0]), 128'(32'hA4));
    chk("r021_ptr", 128'(rr_ptr), 128'(4'b0010));
    cyc();

    // Hold ch1 with its consumer stalled, rr_ptr pointing at ch1.
    rst = 1'b1;
    cyc();
    rst       = 1'b0;
    out_ready = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hB0 + 32'(k);
      cyc();
    end
    in_valid = 1'b1;
    in_data  = 32'hB5;
    #1 chk("r022_ptr", 128'(rr_ptr), 128'(4'b0010));
`ifdef RR_DISPATCH_SKIP_EN
    chk("r023_rdy", 128'(in_ready), 128'(1));
    cyc();
    in_valid = 1'b0;
    #1;
    chk("r023_ch2", 128'(out_data[95:64]), 128'(32'hB5));
    chk("r023_ptr", 128'(rr_ptr), 128'(4'b1000));
    chk("r023_ch1", 128'(out_data[63:32]), 128'(32'hB1));
    cyc();
`else
    for (int k = 0; k < 3; k++) begin
      #1 chk("r022_stall", 128'(in_ready), 128'(0));
      cyc();
    end
    out_ready = 4'b1111;
    #1 chk("r022_rdy", 128'(in_ready), 128'(1));
    cyc();
    in_valid = 1'b0;
    #1;
    chk("r022_ch1", 128'(out_data[63:32]), 128'(32'hB5));
    chk("r022_ptr2", 128'(rr_ptr), 128'(4'b0100));
    cyc();
`endif

    // Fixed routing to the lowest mask bit.
    dispatch_enable = 1'b0;
    single_mask     = 4'b0100;
    out_ready       = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hC0 + 32'(k);
      #1 chk("r024_rdy", 128'(in_ready), 128'(1));
      cyc();
    end
    #1 chk("r024_ch2", 128'(out_data[95:64]), 128'(32'hC2));
    single_mask = 4'b0000;
    #1 chk("r024_zero", 128'(in_ready), 128'(0));
    cyc();
    single_mask = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hD0 + 32'(k);
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("r025_ch1", 128'(out_data[63:32]), 128'(32'hD1));
    chk("r025_vld", 128'(out_valid), 128'(4'b0010));
    cyc();

    // Fill every channel, then pulse reset for one cycle.
    dispatch_enable = 1'b1;
    single_mask     = 4'b0000;
    cyc();                       // drain anything left
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hE0 + 32'(k);
      cyc();
    end
    in_valid = 1'b0;
    #1 chk("r026_full", 128'(out_valid), 128'(4'b1111));
    rst = 1'b1;
    cyc();
    rst       = 1'b0;
    out_ready = 4'b1111;
    #1;
    chk("r026_vld", 128'(out_valid), 128'(4'b0000));
    chk("r026_ptr", 128'(rr_ptr), 128'(4'b0001));
    for (int k = 0; k < 3; k++) cyc();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst             = ($urandom_range(0, 49) == 0);
      dispatch_enable = ($urandom_range(0, 3) != 0);
      single_mask     = N'($urandom_range(0, 15));
      in_valid        = 1'($urandom_range(0, 1));
      in_data         = $urandom;
      out_ready       = N'($urandom_range(0, 15));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_dispatcher.md
RR_DISPATCHER -- requirements
Module: rr_dispatcher

Interface
REQ-001 SHALL have parameter NUM_OUT, default 4, number of output channels (>=2).
REQ-002 SHALL have parameter DATA_W, default 32, payload width.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 SHALL provide the following ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous active-high reset
- dispatch_enable  input  1  1 = round-robin dispatch; 0 = fixed routing by single_mask
- single_mask  input  NUM_OUT  fixed-route channel select, used when dispatch_enable=0
- in_valid  input  1  input word present
- in_data  input  DATA_W  input payload
- in_ready  output  1  input word accepted this cycle when high with in_valid
- out_valid  output  NUM_OUT  per-channel word present
- out_data  output  NUM_OUT*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W]
- out_ready  input  NUM_OUT  per-channel consumer accept
- rr_ptr  output  NUM_OUT  one-hot next round-robin channel

Function
REQ-005 SHALL hold one entry per channel (hold_valid[i], hold_data[i]); out_valid[i] = hold_valid[i]; out_data slice i = hold_data[i].
REQ-006 SHALL treat channel i as free when ~hold_valid[i] | out_ready[i].
REQ-007 SHALL transfer on in_valid & in_ready; the word appears on the target channel out_valid the next cycle (latency 1).
REQ-008 SHALL, in enable mode without the macro, target = rr_ptr and in_ready = free[rr_ptr] (strict rotation; a stalled channel blocks input).
REQ-009 SHALL, on transfer in enable mode, load rr_ptr with the channel after target, wrapping NUM_OUT-1 to 0.
REQ-010 SHALL, when dispatch_enable=0, target the lowest set bit of single_mask, with in_ready = free[target]; single_mask=0 forces in_ready=0; rr_ptr holds.
REQ-011 SHALL, on out_valid[i] & out_ready[i] with no refill, clear hold_valid[i] the next cycle.
REQ-012 SHALL, when drain and refill of the same channel coincide, keep hold_valid[i]=1 with the new data, giving one word per cycle with no bubble.
REQ-013 SHALL never write a channel that is not free, and shall never drop or duplicate a word.
REQ-014 SHALL leave in_ready combinational from out_ready and the mode inputs, with no dependence on in_valid.
REQ-015 SHALL sample dispatch_enable changes per cycle, with no effect on held entries.

Reset
REQ-016 SHALL, on rst, set hold_valid=0 for all channels, set rr_ptr to channel 0 (one-hot 1), and discard any held words.
REQ-017 SHALL, while rst is high, drive out_valid=0 and in_ready=0.

Configuration
REQ-018 SHALL support macro RR_DISPATCH_SKIP_EN:
- Defined: in enable mode, target = first free channel searching from rr_ptr upward with wrap; in_ready = OR of free; REQ-009 applies to the chosen target.
- Undefined: strict rotation per REQ-008.

Structure
REQ-019 SHALL place shared constants in package rr_dispatch_pkg: default NUM_OUT, default DATA_W, and the rr_ptr reset value.
REQ-020 SHALL implement the rotating-priority free-channel search (with RR_DISPATCH_SKIP_EN) as sub-module rotate_priority_pick (inputs: request vector, one-hot start pointer; output: one-hot pick).

Verification (NUM_OUT=4, DATA_W=32)
REQ-021 Reset, out_ready=1111, 5 words 0xA0..0xA4 back-to-back -> ch0..ch3 get 0xA0..0xA3, ch0 gets 0xA4, each 1 cycle after accept, rr_ptr ends 0010.
REQ-022 Macro off, ch1 held with out_ready[1]=0, rr_ptr=0010 -> in_ready=0 until out_ready[1]=1, then the next word lands in ch1.
REQ-023 Macro on, same setup -> word lands in ch2, rr_ptr=1000, ch1 data unchanged.
REQ-024 dispatch_enable=0, single_mask=0100, out_ready=1111, 3 words -> all on ch2 on consecutive cycles without bubbles, rr_ptr unchanged; single_mask=0000 -> in_ready=0.
REQ-025 single_mask=0110 -> words route to ch1 only.
REQ-026 All four channels held, rst pulsed one cycle -> next cycle out_valid=0000, rr_ptr=0001, no held data later emitted.
